// File: rtl/dp_ram_fifo_ctrl_if.sv
// dp_ram_fifo_ctrl_if: producer/consumer valid-ready handshake bundle for the RAM-backed FIFO
interface dp_ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: valid/ready FIFO controller over a dual-port RAM with a registered read port
module dp_ram_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_LVL = 56
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    dp_ram_fifo_ctrl_if.slave bus,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              empty,
    output logic              ovf_err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
);
    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_out_valid, r_ovf;
    logic              w_full, w_wr_fire, w_rd_fire;
    logic [ADDR_W:0]   w_avail;
    assign w_full    = r_count == DEPTH;
    assign w_wr_fire = rst_n && bus.in_valid && !w_full && !flush;
    assign w_rd_fire = r_out_valid && bus.out_ready;
    // entries already in the array before this edge and not being popped can be shown next cycle
    assign w_avail   = r_count - CW'(w_rd_fire);
    assign bus.in_ready  = !w_full && !flush;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = ram_q_b;
    assign count       = r_count;
    assign almost_full = r_count >= CW'(AFULL_LVL);
    assign empty       = r_count == '0;
    assign ovf_err     = r_ovf;
    assign ram_addr_a  = r_wr_ptr;
    assign ram_data_a  = bus.in_data;
    assign ram_we_a    = w_wr_fire;
    // look ahead on a pop so the next word lands in q_b at the same edge
    assign ram_addr_b  = r_rd_ptr + ADDR_W'(w_rd_fire);
    assign ram_we_b    = 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (bus.in_valid && w_full && !flush) r_ovf <= 1'b1;
            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_wr_ptr    <= r_wr_ptr + ADDR_W'(w_wr_fire);
                r_rd_ptr    <= r_rd_ptr + ADDR_W'(w_rd_fire);
                r_count     <= r_count + CW'(w_wr_fire) - CW'(w_rd_fire);
                r_out_valid <= w_avail != '0;
            end
        end
    end
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// tb_dp_ram_fifo_ctrl: randomized scoreboard bench for the RAM-backed FIFO controller with a behavioural RAM
module tb_dp_ram_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [6:0] count;
    logic       almost_full, empty, ovf_err;
    logic [5:0] ram_addr_a, ram_addr_b;
    logic [7:0] ram_data_a, ram_q_b;
    logic       ram_we_a, ram_we_b;
    logic [7:0] mem [64];
    int checks = 0, passed = 0;
    logic [7:0] m_q [$];
    bit m_ov = 0, m_ovf = 0, m_exp_we, m_exp_ir;
    logic obs_we, obs_ir;

    dp_ram_fifo_ctrl_if #(.DATA_W(8)) bus ();

    dp_ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6), .AFULL_LVL(56)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .count(count), .almost_full(almost_full), .empty(empty), .ovf_err(ovf_err),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    // one clock: drive inputs, sample combinational outputs, then advance the queue model
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        bit wr, rd;
        int pre;
        bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy; flush = fl;
        #1;
        obs_we = ram_we_a; obs_ir = bus.in_ready;
        wr = iv && !fl && m_q.size() < 64;
        rd = m_ov && ordy;
        m_exp_we = wr; m_exp_ir = m_q.size() < 64 && !fl;
        @(posedge clk); #1;
        if (iv && !fl && m_q.size() == 64) m_ovf = 1;
        if (fl) begin
            m_q.delete(); m_ov = 0;
        end else begin
            pre = m_q.size();
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(d);
            m_ov = (pre - int'(rd)) > 0;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; flush = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 7'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
        checks++; if ({empty, almost_full, ovf_err} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {empty, almost_full, ovf_err}); else passed++;
        checks++; if (ram_we_b !== 1'b0) $display("FAIL reset_we_b: got %b want 0", ram_we_b); else passed++;
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_first_word();
        cycle(1, 8'hA5, 0, 0);
        checks++; if (obs_we !== 1'b1) $display("FAIL first_we: got %b want 1", obs_we); else passed++;
        checks++; if (bus.out_valid !== 1'b0 || count !== 7'd1) $display("FAIL first_edge1: got valid=%b count=%0d want valid=0 count=1", bus.out_valid, count); else passed++;
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) $display("FAIL first_edge2: got valid=%b data=%h want valid=1 data=a5", bus.out_valid, bus.out_data); else passed++;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'($urandom), 0, 0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || count !== 7'd1) $display("FAIL first_stall%0d: got valid=%b data=%h count=%0d want 1/a5/1", i, bus.out_valid, bus.out_data, count); else passed++;
        end
        cycle(0, 8'h00, 1, 0);
        checks++; if (empty !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL first_pop: got empty=%b valid=%b want 1/0", empty, bus.out_valid); else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            cycle(1, 8'(i), 0, 0);
            checks++; if (count !== 7'(m_q.size())) $display("FAIL fill_count%0d: got %0d want %0d", i, count, m_q.size()); else passed++;
            checks++; if (almost_full !== (m_q.size() >= 56)) $display("FAIL fill_afull%0d: got %b want %b", i, almost_full, m_q.size() >= 56); else passed++;
        end
        checks++; if (bus.in_ready !== 1'b0 || count !== 7'd64) $display("FAIL fill_full: got ready=%b count=%0d want 0/64", bus.in_ready, count); else passed++;
        cycle(1, 8'hFF, 0, 0);
        checks++; if (obs_we !== 1'b0) $display("FAIL fill_ovf_we: got %b want 0", obs_we); else passed++;
        checks++; if (ovf_err !== 1'b1 || count !== 7'd64) $display("FAIL fill_ovf: got ovf=%b count=%0d want 1/64", ovf_err, count); else passed++;
    endtask

    task automatic test_drain();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) $display("FAIL drain_head: got valid=%b data=%h want 1/00", bus.out_valid, bus.out_data); else passed++;
        for (int i = 0; i < 64; i++) begin
            cycle(0, 8'h00, 1, 0);
            if (i < 63) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i + 1)) $display("FAIL drain_pop%0d: got valid=%b data=%h want 1/%h", i, bus.out_valid, bus.out_data, 8'(i + 1)); else passed++;
            end
        end
        checks++; if (empty !== 1'b1 || bus.out_valid !== 1'b0 || count !== 7'd0) $display("FAIL drain_end: got empty=%b valid=%b count=%0d want 1/0/0", empty, bus.out_valid, count); else passed++;
    endtask

    task automatic test_wrap();
        repeat (3) cycle(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 100; i++) begin
            cycle(1, 8'($urandom), 1, 0);
            checks++; if (count !== 7'd3 || bus.out_valid !== 1'b1 || bus.out_data !== m_q[0]) $display("FAIL wrap%0d: got count=%0d valid=%b data=%h want 3/1/%h", i, count, bus.out_valid, bus.out_data, m_q[0]); else passed++;
        end
        for (int i = 0; i < 10 && m_q.size() > 0; i++) begin
            if (m_ov) begin
                checks++; if (bus.out_data !== m_q[0]) $display("FAIL wrap_drain%0d: got %h want %h", i, bus.out_data, m_q[0]); else passed++;
            end
            cycle(0, 8'h00, 1, 0);
        end
        checks++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passed++;
    endtask

    task automatic test_flush();
        logic [7:0] d;
        repeat (10) cycle(1, 8'($urandom), 0, 0);
        checks++; if (count !== 7'd10) $display("FAIL flush_pre: got %0d want 10", count); else passed++;
        cycle(1, 8'h77, 0, 1);
        checks++; if (obs_ir !== 1'b0 || obs_we !== 1'b0) $display("FAIL flush_gate: got ready=%b we=%b want 0/0", obs_ir, obs_we); else passed++;
        checks++; if (count !== 7'd0 || bus.out_valid !== 1'b0 || empty !== 1'b1) $display("FAIL flush_clear: got count=%0d valid=%b empty=%b want 0/0/1", count, bus.out_valid, empty); else passed++;
        checks++; if (ovf_err !== m_ovf) $display("FAIL flush_ovf: got %b want %b", ovf_err, m_ovf); else passed++;
        d = 8'($urandom);
        cycle(1, d, 0, 0);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_lat1: got %b want 0", bus.out_valid); else passed++;
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d) $display("FAIL flush_lat2: got valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, d); else passed++;
        cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        logic iv, ordy, fl;
        for (int i = 0; i < 400; i++) begin
            iv   = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ordy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl   = $urandom_range(0, 59) == 0;
            cycle(iv, 8'($urandom), ordy, fl);
            checks++; if (obs_we !== m_exp_we || obs_ir !== m_exp_ir) $display("FAIL rand_comb%0d: got we=%b ready=%b want %b/%b", i, obs_we, obs_ir, m_exp_we, m_exp_ir); else passed++;
            checks++; if (count !== 7'(m_q.size()) || bus.out_valid !== m_ov) $display("FAIL rand_state%0d: got count=%0d valid=%b want %0d/%b", i, count, bus.out_valid, m_q.size(), m_ov); else passed++;
            checks++; if (almost_full !== (m_q.size() >= 56) || empty !== (m_q.size() == 0) || ovf_err !== m_ovf) $display("FAIL rand_flags%0d: got af=%b e=%b ovf=%b", i, almost_full, empty, ovf_err); else passed++;
            if (m_ov) begin
                checks++; if (bus.out_data !== m_q[0]) $display("FAIL rand_data%0d: got %h want %h", i, bus.out_data, m_q[0]); else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        cycle(1, 8'h00, 1, 1);
        repeat (20) cycle(1, 8'($urandom), 0, 0);
        checks++; if (count !== 7'd20) $display("FAIL arst_pre: got %0d want 20", count); else passed++;
        #2 rst_n = 0;
        #1;
        checks++; if (count !== 7'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL arst_state: got count=%0d valid=%b ready=%b want 0/0/1", count, bus.out_valid, bus.in_ready); else passed++;
        checks++; if ({empty, almost_full, ovf_err, ram_we_a} !== 4'b1000) $display("FAIL arst_flags: got %b want 1000", {empty, almost_full, ovf_err, ram_we_a}); else passed++;
        m_q.delete(); m_ov = 0; m_ovf = 0;
        bus.in_valid = 0;
        @(negedge clk) rst_n = 1;
        d = 8'($urandom);
        cycle(1, d, 0, 0);
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d || count !== 7'd1) $display("FAIL arst_push: got valid=%b data=%h count=%0d want 1/%h/1", bus.out_valid, bus.out_data, count, d); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
- Controller that turns the 64x8 dual-port RAM into a synchronous FIFO with valid/ready handshakes on both sides.
- Port A of the RAM is used for writes only; port B is used for reads only, with we_b tied low.
- Sits directly upstream of the RAM, driving its address, data and write-enable pins.
- Hides the RAM's one-cycle registered read (q_b) so the consumer sees show-ahead data at full throughput.

Parameters:
- DATA_W, 8, word width; must match the RAM data width.
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W = 64.
- AFULL_LVL, 56, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO state.
- in_data  in  DATA_W  write data.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  DATA_W  head-of-FIFO word; equals ram_q_b.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  consumer takes the word.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- empty  out  1  count == 0.
- ovf_err  out  1  sticky flag: in_valid was high while in_ready was low.
- ram_addr_a  out  ADDR_W  write pointer to RAM port A.
- ram_data_a  out  DATA_W  equals in_data.
- ram_we_a  out  1  write strobe.
- ram_addr_b  out  ADDR_W  read address to RAM port B.
- ram_we_b  out  1  constant 0.
- ram_q_b  in  DATA_W  RAM port-B registered read data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, ovf_err=0.
  - Resulting outputs: in_ready=1, empty=1, almost_full=0.
  - RAM contents and ram_q_b are undefined after reset; out_valid=0 masks them.
- Definitions:
  - wr_fire = in_valid & in_ready.
  - rd_fire = out_valid & out_ready.
  - in_ready = (count != DEPTH), combinational.
  - A write is refused when full, even if a pop happens in the same cycle.
- Write path (combinational):
  - ram_we_a = wr_fire.
  - ram_addr_a = wr_ptr.
  - ram_data_a = in_data.
  - On wr_fire, wr_ptr increments and wraps 63->0 modulo DEPTH.
- Read path:
  - ram_addr_b = rd_fire ? rd_ptr+1 : rd_ptr (mod DEPTH), combinational, so the next word is loaded into ram_q_b at the pop edge.
  - On rd_fire, rd_ptr increments with wrap.
  - out_data = ram_q_b (no extra register).
- count update:
  - count_next = count + wr_fire - rd_fire.
  - A simultaneous push and pop leaves count unchanged.
- out_valid (registered):
  - out_valid_next = ((count - rd_fire) != 0).
  - Only entries written at earlier edges qualify, because the RAM array updates at the write edge and q_b reflects it one edge later.
  - Write into an empty FIFO at edge t: out_valid=1 and out_data valid after edge t+1, giving 2-cycle first-word latency.
  - Steady state: one pop per cycle with no bubbles while count - rd_fire > 0.
- Same-address hazard: writing the slot addressed by ram_addr_b in the same cycle returns old data on q_b. This only occurs when that slot is not yet counted, so out_valid is 0 for it.
- Flush:
  - flush=1 at an edge clears wr_ptr, rd_ptr, count and out_valid, and sets ram_we_a=0 in that cycle.
  - in_ready is forced to 0 while flush=1.
  - ovf_err is not cleared by flush; only reset clears it.
- Overflow: ovf_err sets on any edge with in_valid=1 and count==DEPTH and flush=0. It is sticky.
- Handshake rules:
  - out_data/out_valid must stay stable while out_valid=1 and out_ready=0; this holds because addr_b is held at rd_ptr.
  - in_valid may drop without in_ready.
- Reset mid-operation: all state clears immediately and asynchronously; any RAM write strobe in flight drops with it.

Test Plan:
- Reset, then push 0xA5 one cycle with out_ready=0 -> out_valid=0 after edge 1; out_valid=1 and out_data=0xA5 after edge 2; count=1; held stable for 5 stall cycles.
- Push 64 words 0x00..0x3F back-to-back with out_ready=0 -> in_ready=0 and count=64 after 64th edge; almost_full first high at count=56; extra in_valid cycle sets ovf_err=1, RAM not written.
- From full, out_ready=1 continuously -> out_data sequence 0x00..0x3F on consecutive cycles with no bubbles; empty=1 and out_valid=0 after the 64th pop.
- Continuous push and pop at count=3 for 100 cycles with pointers crossing 63->0 -> count stays 3; output order matches input order across wrap.
- Assert flush with count=10 -> next cycle count=0, out_valid=0, empty=1; ovf_err is unchanged; next push reappears after the 2-cycle latency.
- Drop rst_n mid-stream with count=20, asynchronously between edges -> outputs return to reset values before the next clock edge; the first post-reset push reads back correctly.
